ins_sequencer: RTL and testbench

//  Instruction sequencer for the conv/pool/ReLU datapath. Fetches instructions from the

---
 rtl/tpu_isa_pkg.sv | 42 ++++
 rtl/ins_decode_lut.sv | 57 +++++
 rtl/ins_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ins_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// Instruction set definitions shared by the sequencer, its decoder and software-side tooling.
// The instruction word is {img_size, img_addr, ker_addr, out_addr, opcode}, opcode in the LSBs.
package tpu_isa_pkg;

  localparam int OPCODE_W   = 4;
  localparam int ADDR_W     = 10;
  localparam int IMG_SIZE_W = 5;

  localparam int OPCODE_LSB   = 0;
  localparam int OUT_ADDR_LSB = OPCODE_LSB + OPCODE_W;
  localparam int KER_ADDR_LSB = OUT_ADDR_LSB + ADDR_W;
  localparam int IMG_ADDR_LSB = KER_ADDR_LSB + ADDR_W;
  localparam int IMG_SIZE_LSB = IMG_ADDR_LSB + ADDR_W;
  localparam int INS_W        = IMG_SIZE_LSB + IMG_SIZE_W;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_CONV2   = 4'd1,
    OP_CONV3   = 4'd2,
    OP_CONV5   = 4'd3,
    OP_MAXPOOL = 4'd4,
    OP_RELU    = 4'd5,
    OP_HALT    = 4'd6,
    OP_LOOP    = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    PE_NONE    = 2'b00,
    PE_CONV    = 2'b01,
    PE_MAXPOOL = 2'b10,
    PE_RELU    = 2'b11
  } pe_op_e;

  typedef struct packed {
    logic [IMG_SIZE_W-1:0] img_size;
    logic [ADDR_W-1:0]     img_addr;
    logic [ADDR_W-1:0]     ker_addr;
    logic [ADDR_W-1:0]     out_addr;
    logic [OPCODE_W-1:0]   opcode;
  } ins_word_t;

endpackage

// File: rtl/ins_decode_lut.sv
// Combinational opcode decoder: PE operation, fetch/write enables, kernel size and
// the control-flow flags the sequencer needs to choose its next state.
module ins_decode_lut
  import tpu_isa_pkg::*;
#(
  parameter int OPCODE_WIDTH      = 4,
  parameter int KERNEL_SIZE_WIDTH = 3
) (
  input  logic [OPCODE_WIDTH-1:0]      i_opcode,
  output pe_op_e                       o_pe_op,
  output logic                         o_img_en,
  output logic                         o_ker_en,
  output logic                         o_wr_en,
  output logic [KERNEL_SIZE_WIDTH-1:0] o_ker_size,
  output logic                         o_is_halt,
  output logic                         o_is_loop,
  output logic                         o_illegal
);

  // Every datapath op reads the image and writes a result; only conv needs kernel data.
  always_comb begin
    o_pe_op    = PE_NONE;
    o_img_en   = 1'b0;
    o_ker_en   = 1'b0;
    o_wr_en    = 1'b0;
    o_ker_size = '0;
    o_is_halt  = 1'b0;
    o_is_loop  = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OPCODE_WIDTH'(OP_NOP): ;
      OPCODE_WIDTH'(OP_CONV2): begin
        o_pe_op = PE_CONV; o_img_en = 1'b1; o_ker_en = 1'b1; o_wr_en = 1'b1;
        o_ker_size = KERNEL_SIZE_WIDTH'(2);
      end
      OPCODE_WIDTH'(OP_CONV3): begin
        o_pe_op = PE_CONV; o_img_en = 1'b1; o_ker_en = 1'b1; o_wr_en = 1'b1;
        o_ker_size = KERNEL_SIZE_WIDTH'(3);
      end
      OPCODE_WIDTH'(OP_CONV5): begin
        o_pe_op = PE_CONV; o_img_en = 1'b1; o_ker_en = 1'b1; o_wr_en = 1'b1;
        o_ker_size = KERNEL_SIZE_WIDTH'(5);
      end
      OPCODE_WIDTH'(OP_MAXPOOL): begin
        o_pe_op = PE_MAXPOOL; o_img_en = 1'b1; o_wr_en = 1'b1;
        o_ker_size = KERNEL_SIZE_WIDTH'(2);
      end
      OPCODE_WIDTH'(OP_RELU): begin
        o_pe_op = PE_RELU; o_img_en = 1'b1; o_wr_en = 1'b1;
      end
      OPCODE_WIDTH'(OP_HALT): o_is_halt = 1'b1;
      OPCODE_WIDTH'(OP_LOOP): o_is_loop = 1'b1;
      default:                o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ins_sequencer.sv
// Instruction sequencer: fetches from instruction BRAM, issues one command at a time to the
// datapath over a valid/ready handshake, and handles HALT, single-level LOOP and traps.
module ins_sequencer
  import tpu_isa_pkg::*;
#(
  parameter int INS_ADDR_WIDTH    = 10,
  parameter int ADDR_WIDTH        = 10,
  parameter int IMG_SIZE_WIDTH    = 5,
  parameter int KERNEL_SIZE_WIDTH = 3,
  parameter int OPCODE_WIDTH      = 4
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              start,
  output logic                                              bram_ins_en,
  output logic [INS_ADDR_WIDTH-1:0]                         bram_ins_addr,
  input  logic [OPCODE_WIDTH+3*ADDR_WIDTH+IMG_SIZE_WIDTH-1:0] bram_ins_din,
  output logic                                              cmd_valid,
  input  logic                                              cmd_ready,
  output logic [1:0]                                        pe_op,
  output logic                                              img_fetch_en,
  output logic                                              ker_fetch_en,
  output logic                                              write_en,
  output logic [KERNEL_SIZE_WIDTH-1:0]                      ker_size,
  output logic [IMG_SIZE_WIDTH-1:0]                         img_size,
  output logic [ADDR_WIDTH-1:0]                             img_addr,
  output logic [ADDR_WIDTH-1:0]                             ker_addr,
  output logic [ADDR_WIDTH-1:0]                             out_addr,
  input  logic                                              op_done,
  output logic                                              busy,
  output logic                                              halted,
  output logic                                              err_illegal
);

  localparam int OUT_LSB  = OPCODE_WIDTH;
  localparam int KER_LSB  = OUT_LSB + ADDR_WIDTH;
  localparam int IMG_LSB  = KER_LSB + ADDR_WIDTH;
  localparam int SIZE_LSB = IMG_LSB + ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_BUSY, S_HALTED
  } state_e;

  state_e                        r_state, w_stateNext;
  logic [INS_ADDR_WIDTH-1:0]     r_pc, w_pcNext, r_loopPc, w_loopPcNext;
  logic [IMG_SIZE_WIDTH-1:0]     r_loopCnt, w_loopCntNext;
  logic                          r_loopActive, w_loopActiveNext;
  logic                          r_err, w_errNext;
  pe_op_e                        r_peOp;
  logic                          r_imgEn, r_kerEn, r_wrEn;
  logic [KERNEL_SIZE_WIDTH-1:0]  r_kerSize;
  logic [IMG_SIZE_WIDTH-1:0]     r_imgSize;
  logic [ADDR_WIDTH-1:0]         r_imgAddr, r_kerAddr, r_outAddr;

  logic [OPCODE_WIDTH-1:0]       w_dinOpcode;
  logic [IMG_SIZE_WIDTH-1:0]     w_dinSize;
  logic [ADDR_WIDTH-1:0]         w_dinOutAddr;
  logic [INS_ADDR_WIDTH-1:0]     w_target;
  pe_op_e                        w_decPeOp;
  logic                          w_decImgEn, w_decKerEn, w_decWrEn;
  logic [KERNEL_SIZE_WIDTH-1:0]  w_decKerSize;
  logic                          w_isHalt, w_isLoop, w_illegal;
  logic                          w_pcLast;
  state_e                        w_advState;
  logic [INS_ADDR_WIDTH-1:0]     w_advPc;

  assign w_dinOpcode  = bram_ins_din[OPCODE_WIDTH-1:0];
  assign w_dinOutAddr = bram_ins_din[OUT_LSB +: ADDR_WIDTH];
  assign w_dinSize    = bram_ins_din[SIZE_LSB +: IMG_SIZE_WIDTH];
  assign w_target     = w_dinOutAddr[INS_ADDR_WIDTH-1:0];

  ins_decode_lut #(
    .OPCODE_WIDTH      (OPCODE_WIDTH),
    .KERNEL_SIZE_WIDTH (KERNEL_SIZE_WIDTH)
  ) u_decode (
    .i_opcode   (w_dinOpcode),
    .o_pe_op    (w_decPeOp),
    .o_img_en   (w_decImgEn),
    .o_ker_en   (w_decKerEn),
    .o_wr_en    (w_decWrEn),
    .o_ker_size (w_decKerSize),
    .o_is_halt  (w_isHalt),
    .o_is_loop  (w_isLoop),
    .o_illegal  (w_illegal)
  );

  // Advancing past the last address stops the program instead of wrapping pc.
  assign w_pcLast   = &r_pc;
  assign w_advState = w_pcLast ? S_HALTED : S_FETCH;
  assign w_advPc    = w_pcLast ? r_pc : r_pc + INS_ADDR_WIDTH'(1);

  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_loopPcNext     = r_loopPc;
    w_loopCntNext    = r_loopCnt;
    w_loopActiveNext = r_loopActive;
    w_errNext        = r_err;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_stateNext      = S_FETCH;
          w_pcNext         = '0;
          w_loopPcNext     = '0;
          w_loopCntNext    = '0;
          w_loopActiveNext = 1'b0;
          w_errNext        = 1'b0;
        end
      end
      S_FETCH: w_stateNext = S_DECODE;
      S_DECODE: begin
        if (w_illegal || (w_isLoop && r_loopActive && (r_pc != r_loopPc))) begin
          w_errNext   = 1'b1;
          w_stateNext = S_HALTED;
        end else if (w_isHalt) begin
          w_stateNext = S_HALTED;
        end else if (w_isLoop) begin
          if (!r_loopActive && (w_dinSize != '0)) begin
            w_loopCntNext    = w_dinSize - IMG_SIZE_WIDTH'(1);
            w_loopActiveNext = 1'b1;
            w_loopPcNext     = r_pc;
            w_pcNext         = w_target;
            w_stateNext      = S_FETCH;
          end else if (r_loopActive && (r_loopCnt != '0)) begin
            w_loopCntNext = r_loopCnt - IMG_SIZE_WIDTH'(1);
            w_pcNext      = w_target;
            w_stateNext   = S_FETCH;
          end else begin
            w_loopActiveNext = 1'b0;
            w_pcNext         = w_advPc;
            w_stateNext      = w_advState;
          end
        end else if (w_decPeOp != PE_NONE) begin
          w_stateNext = S_ISSUE;
        end else begin
          w_pcNext    = w_advPc;
          w_stateNext = w_advState;
        end
      end
      S_ISSUE: if (cmd_ready) w_stateNext = S_BUSY;
      S_BUSY: begin
        if (op_done) begin
          w_pcNext    = w_advPc;
          w_stateNext = w_advState;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // The instruction register and its decode are captured once in DECODE so the command
  // stays stable for however long the execution side stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_loopPc     <= '0;
      r_loopCnt    <= '0;
      r_loopActive <= 1'b0;
      r_err        <= 1'b0;
      r_peOp       <= PE_NONE;
      r_imgEn      <= 1'b0;
      r_kerEn      <= 1'b0;
      r_wrEn       <= 1'b0;
      r_kerSize    <= '0;
      r_imgSize    <= '0;
      r_imgAddr    <= '0;
      r_kerAddr    <= '0;
      r_outAddr    <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_loopPc     <= w_loopPcNext;
      r_loopCnt    <= w_loopCntNext;
      r_loopActive <= w_loopActiveNext;
      r_err        <= w_errNext;
      if (r_state == S_DECODE) begin
        r_peOp    <= w_decPeOp;
        r_imgEn   <= w_decImgEn;
        r_kerEn   <= w_decKerEn;
        r_wrEn    <= w_decWrEn;
        r_kerSize <= w_decKerSize;
        r_imgSize <= w_dinSize;
        r_imgAddr <= bram_ins_din[IMG_LSB +: ADDR_WIDTH];
        r_kerAddr <= bram_ins_din[KER_LSB +: ADDR_WIDTH];
        r_outAddr <= w_dinOutAddr;
      end
    end
  end

  assign bram_ins_en   = (r_state == S_FETCH);
  assign bram_ins_addr = r_pc;
  assign cmd_valid     = (r_state == S_ISSUE);
  assign pe_op         = r_peOp;
  assign img_fetch_en  = r_imgEn & cmd_valid;
  assign ker_fetch_en  = r_kerEn & cmd_valid;
  assign write_en      = r_wrEn & cmd_valid;
  assign ker_size      = r_kerSize;
  assign img_size      = r_imgSize;
  assign img_addr      = r_imgAddr;
  assign ker_addr      = r_kerAddr;
  assign out_addr      = r_outAddr;
  assign busy          = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted        = (r_state == S_HALTED);
  assign err_illegal   = r_err;

endmodule

// File: tb/tb_ins_sequencer.sv
// Self-checking bench for ins_sequencer: directed programs for latency, stalls, LOOP, traps,
// reset and end-of-memory, then random programs compared against a program-level model.
module tb_ins_sequencer;
  import tpu_isa_pkg::*;

  localparam int IAW = 4;
  localparam int IW  = INS_W;

  typedef struct packed {
    logic [1:0]  peOp;
    logic [2:0]  kerSize;
    logic        imgEn;
    logic        kerEn;
    logic        wrEn;
    logic [4:0]  imgSize;
    logic [9:0]  imgAddr;
    logic [9:0]  kerAddr;
    logic [9:0]  outAddr;
  } cmd_t;

  logic           clk = 1'b0;
  logic           rstn, start, cmd_ready, op_done;
  logic           bram_ins_en;
  logic [IAW-1:0] bram_ins_addr;
  logic [IW-1:0]  bram_ins_din;
  logic           cmd_valid, img_fetch_en, ker_fetch_en, write_en;
  logic [1:0]     pe_op;
  logic [2:0]     ker_size;
  logic [4:0]     img_size;
  logic [9:0]     img_addr, ker_addr, out_addr;
  logic           busy, halted, err_illegal;

  ins_word_t mem [16];
  cmd_t      gotQ [$];
  cmd_t      expQ [$];
  int        nChecks = 0;
  int        nPass   = 0;

  ins_sequencer #(
    .INS_ADDR_WIDTH    (IAW),
    .ADDR_WIDTH        (10),
    .IMG_SIZE_WIDTH    (5),
    .KERNEL_SIZE_WIDTH (3),
    .OPCODE_WIDTH      (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .bram_ins_en   (bram_ins_en),
    .bram_ins_addr (bram_ins_addr),
    .bram_ins_din  (bram_ins_din),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .pe_op         (pe_op),
    .img_fetch_en  (img_fetch_en),
    .ker_fetch_en  (ker_fetch_en),
    .write_en      (write_en),
    .ker_size      (ker_size),
    .img_size      (img_size),
    .img_addr      (img_addr),
    .ker_addr      (ker_addr),
    .out_addr      (out_addr),
    .op_done       (op_done),
    .busy          (busy),
    .halted        (halted),
    .err_illegal   (err_illegal)
  );

  always #5 clk = ~clk;

  // Instruction BRAM with one cycle of read latency.
  always @(posedge clk) if (bram_ins_en) bram_ins_din <= mem[bram_ins_addr];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ins_word_t makeIns(input int op, input int size, input int img,
                                        input int ker, input int out);
    ins_word_t w;
    w.opcode   = 4'(op);
    w.img_size = 5'(size);
    w.img_addr = 10'(img);
    w.ker_addr = 10'(ker);
    w.out_addr = 10'(out);
    return w;
  endfunction

  // What the datapath should receive for an issuing opcode, straight from the ISA table.
  function automatic cmd_t expectCmd(input ins_word_t w);
    cmd_t c;
    c = '0;
    case (int'(w.opcode))
      1: begin c.peOp = 2'b01; c.kerSize = 3'd2; end
      2: begin c.peOp = 2'b01; c.kerSize = 3'd3; end
      3: begin c.peOp = 2'b01; c.kerSize = 3'd5; end
      4: begin c.peOp = 2'b10; c.kerSize = 3'd2; end
      5: begin c.peOp = 2'b11; c.kerSize = 3'd0; end
      default: ;
    endcase
    c.imgEn   = 1'b1;
    c.wrEn    = 1'b1;
    c.kerEn   = (int'(w.opcode) <= 3);
    c.imgSize = w.img_size;
    c.imgAddr = w.img_addr;
    c.kerAddr = w.ker_addr;
    c.outAddr = w.out_addr;
    return c;
  endfunction

  function automatic cmd_t captureCmd();
    cmd_t c;
    c.peOp = pe_op; c.kerSize = ker_size;
    c.imgEn = img_fetch_en; c.kerEn = ker_fetch_en; c.wrEn = write_en;
    c.imgSize = img_size; c.imgAddr = img_addr; c.kerAddr = ker_addr; c.outAddr = out_addr;
    return c;
  endfunction

  function automatic logic [63:0] allOutputs();
    return 64'({bram_ins_en, bram_ins_addr, cmd_valid, pe_op, img_fetch_en, ker_fetch_en,
                write_en, ker_size, img_size, img_addr, ker_addr, out_addr, busy, halted,
                err_illegal});
  endfunction

  // Program-level interpreter: walks the program as the ISA describes it and lists the
  // commands that must be issued, plus where and how execution ends.
  function automatic void modelRun(output int finalPc, output bit finalErr);
    int pc = 0;
    int cnt = 0;
    int loopPc = 0;
    bit active = 1'b0;
    ins_word_t w;
    expQ.delete();
    finalErr = 1'b0;
    for (int step = 0; step < 4000; step++) begin
      w = mem[pc];
      if (int'(w.opcode) >= 8) begin finalErr = 1'b1; break; end
      if (int'(w.opcode) == 6) break;
      if (int'(w.opcode) == 7) begin
        if (active && pc != loopPc) begin finalErr = 1'b1; break; end
        if (active && cnt > 0) begin
          cnt--; pc = int'(w.out_addr[3:0]); continue;
        end
        if (!active && w.img_size != 0) begin
          cnt = int'(w.img_size) - 1; active = 1'b1; loopPc = pc;
          pc = int'(w.out_addr[3:0]); continue;
        end
        active = 1'b0;
      end else if (int'(w.opcode) != 0) begin
        expQ.push_back(expectCmd(w));
      end
      if (pc == 15) break;
      pc++;
    end
    finalPc = pc;
  endfunction

  task automatic fillMem(input int op);
    for (int i = 0; i < 16; i++) mem[i] = makeIns(op, 0, 0, 0, 0);
  endtask

  task automatic randomProgram();
    int op;
    for (int i = 0; i < 16; i++) begin
      op = int'($urandom_range(0, 33));
      if (op >= 32) op = 8 + int'($urandom_range(0, 7));
      else op = op % 8;
      if (op == 7)
        mem[i] = makeIns(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      else
        mem[i] = makeIns(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end
  endtask

  // Pulses start; returns on the negedge of the first FETCH cycle.
  task automatic applyStimulus();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic waitHalted(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    checkOutput(tag, halted, 1);
  endtask

  // Runs a program to HALTED, logging handshakes. Random mode jitters cmd_ready, op_done and
  // stray start pulses, and checks the command holds steady while stalled.
  task automatic runProg(input string tag, input bit rnd, input int budget);
    cmd_t prevCmd = '0;
    bit   holdPending = 1'b0;
    gotQ.delete();
    applyStimulus();
    for (int c = 0; c < budget && !halted; c++) begin
      if (holdPending) begin
        checkOutput({tag, "_holdValid"}, cmd_valid, 1);
        checkOutput({tag, "_holdFields"}, captureCmd(), prevCmd);
      end
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      op_done   = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      start     = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      #1;
      if (cmd_valid && cmd_ready) gotQ.push_back(captureCmd());
      holdPending = cmd_valid && !cmd_ready;
      prevCmd = captureCmd();
      @(negedge clk);
    end
    cmd_ready = 1'b0; op_done = 1'b0; start = 1'b0;
    checkOutput({tag, "_halted"}, halted, 1);
  endtask

  task automatic compareModel(input string tag);
    int finalPc;
    bit finalErr;
    int n;
    modelRun(finalPc, finalErr);
    checkOutput({tag, "_issueCount"}, 64'(gotQ.size()), 64'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_cmd%0d", tag, i), gotQ[i], expQ[i]);
    checkOutput({tag, "_err"}, err_illegal, 64'(finalErr));
    checkOutput({tag, "_finalPc"}, bram_ins_addr, 64'(finalPc));
  endtask

  initial begin
    cmd_t exp1;
    cmd_t got;
    int   hs;
    bit   sawValid;

    rstn = 1'b0; start = 1'b0; cmd_ready = 1'b0; op_done = 1'b0;
    fillMem(6);
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 0);
    rstn = 1'b1;

    // Test 1: CONV3 then HALT, start-to-valid latency and decoded fields.
    $display("[TB] test 1: conv3 latency");
    mem[0] = makeIns(2, 8, 'h010, 'h020, 'h030);
    mem[1] = makeIns(6, 0, 0, 0, 0);
    exp1 = '{peOp: 2'b01, kerSize: 3'd3, imgEn: 1'b1, kerEn: 1'b1, wrEn: 1'b1,
             imgSize: 5'd8, imgAddr: 10'h010, kerAddr: 10'h020, outAddr: 10'h030};
    applyStimulus();
    checkOutput("t1FetchEn", bram_ins_en, 1);
    checkOutput("t1FetchAddr", bram_ins_addr, 0);
    checkOutput("t1NoValidT1", cmd_valid, 0);
    @(negedge clk);
    checkOutput("t1NoValidT2", cmd_valid, 0);
    @(negedge clk);
    checkOutput("t1ValidT3", cmd_valid, 1);
    checkOutput("t1Cmd", captureCmd(), exp1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("t1BusyNoValid", {busy, cmd_valid}, 2'b10);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    waitHalted("t1Halted", 20);
    checkOutput("t1HaltAddr", bram_ins_addr, 1);
    checkOutput("t1NotBusy", busy, 0);

    // Test 2: same program, execution side stalls for five cycles.
    $display("[TB] test 2: stalled handshake");
    applyStimulus();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2HoldValid%0d", i), cmd_valid, 1);
      checkOutput($sformatf("t2HoldCmd%0d", i), captureCmd(), exp1);
      checkOutput($sformatf("t2HoldBusy%0d", i), busy, 1);
      @(negedge clk);
    end
    cmd_ready = 1'b1; op_done = 1'b1; hs = 0;
    for (int i = 0; i < 20 && !halted; i++) begin
      #1;
      if (cmd_valid && cmd_ready) hs++;
      @(negedge clk);
    end
    cmd_ready = 1'b0; op_done = 1'b0;
    checkOutput("t2Handshakes", 64'(hs), 1);
    checkOutput("t2Halted", halted, 1);

    // Test 3: RELU body looped with N=2 runs three times.
    $display("[TB] test 3: loop");
    fillMem(6);
    mem[0] = makeIns(5, 4, 'h100, 'h200, 'h300);
    mem[1] = makeIns(7, 2, 0, 0, 0);
    runProg("t3", 1'b0, 200);
    checkOutput("t3Count", 64'(gotQ.size()), 3);
    foreach (gotQ[i]) begin
      got = gotQ[i];
      checkOutput($sformatf("t3PeOp%0d", i), got.peOp, 2'b11);
      checkOutput($sformatf("t3KerEn%0d", i), got.kerEn, 0);
    end
    compareModel("t3");

    // Test 4: NOPs issue nothing; halted follows from two cycles per NOP.
    $display("[TB] test 4: nops");
    fillMem(6);
    for (int i = 0; i < 3; i++) mem[i] = makeIns(0, 0, 0, 0, 0);
    sawValid = 1'b0;
    applyStimulus();
    for (int i = 0; i < 7; i++) begin
      sawValid |= cmd_valid;
      @(negedge clk);
    end
    checkOutput("t4NotYetHalted", halted, 0);
    @(negedge clk);
    checkOutput("t4HaltedT9", halted, 1);
    checkOutput("t4NoValid", sawValid, 0);
    checkOutput("t4HaltAddr", bram_ins_addr, 3);

    // Test 5: MAXPOOL then an illegal opcode; restart clears the trap.
    $display("[TB] test 5: illegal opcode");
    fillMem(6);
    mem[0] = makeIns(4, 12, 'h0AA, 'h0BB, 'h0CC);
    mem[1] = makeIns('hA, 0, 0, 0, 0);
    runProg("t5", 1'b0, 200);
    checkOutput("t5Count", 64'(gotQ.size()), 1);
    checkOutput("t5Err", err_illegal, 1);
    compareModel("t5");
    applyStimulus();
    checkOutput("t5RestartErr", err_illegal, 0);
    checkOutput("t5RestartAddr", bram_ins_addr, 0);
    checkOutput("t5RestartBusy", {busy, halted}, 2'b10);
    cmd_ready = 1'b1; op_done = 1'b1;
    waitHalted("t5ReHalted", 30);
    cmd_ready = 1'b0; op_done = 1'b0;
    checkOutput("t5ReErr", err_illegal, 1);

    // Test 6a: reset while the PE array is busy.
    $display("[TB] test 6: reset mid-op and end of memory");
    fillMem(6);
    mem[0] = makeIns(2, 8, 'h010, 'h020, 'h030);
    applyStimulus();
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("t6aInBusy", {busy, cmd_valid}, 2'b10);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t6aResetOutputs", allOutputs(), 0);
    rstn = 1'b1;

    // Test 6b: sixteen RELUs and no HALT stop at the last address.
    for (int i = 0; i < 16; i++) mem[i] = makeIns(5, i, i, 2 * i, 3 * i);
    runProg("t6b", 1'b0, 300);
    checkOutput("t6bCount", 64'(gotQ.size()), 16);
    checkOutput("t6bLastAddr", bram_ins_addr, 15);
    compareModel("t6b");

    // Random programs with random handshake timing against the program-level model.
    $display("[TB] random programs");
    for (int r = 0; r < 25; r++) begin
      randomProgram();
      runProg($sformatf("rnd%0d", r), 1'b1, 3000);
      compareModel($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
